// File: rtl/alu_dword_sequencer_if.sv
// alu_dword_sequencer_if
// Request/response bundle between the datapath issue logic and the
// double-word ALU sequencer.
//   req_valid/req_ready : request handshake
//   req_mode            : ALU mode (0 AND,1 OR,2 XOR,3 SHCL,4 SHCR,5 NOT,6 SUB,7 ADD)
//   req_a/req_b         : 2*WIDTH operands
//   req_cin             : carry in
//   rsp_valid/rsp_ready : response handshake
//   rsp_result          : 2*WIDTH result
//   rsp_carry/rsp_zero  : result flags
// master = requester side, slave = sequencer side.
interface alu_dword_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_mode;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic               req_cin;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*WIDTH-1:0] rsp_result;
  logic               rsp_carry;
  logic               rsp_zero;

  modport master (
    output req_valid, req_mode, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

  modport slave (
    input  req_valid, req_mode, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu_dword_sequencer.sv
// alu_dword_sequencer
// Drives a WIDTH-bit combinational ALU through two to four passes to execute
// one 2*WIDTH-bit operation, chaining carries between the word halves.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   bus (slave)      : request/response handshake bundle
//   alu_in_A/B       : ALU operands (registered)
//   alu_mode         : ALU mode (registered)
//   alu_carry_in     : ALU carry in (registered)
//   alu_enable       : ALU output enable, active low (registered)
//   alu_out          : ALU result (combinational from the ALU)
//   alu_carry_out    : ALU carry out
//   alu_zero_flag    : ALU zero flag, not used
// Optional build macro ALU_SEQ_SKIP_CARRY_EN: ADD/SUB skip the carry-seed
// passes whose added value would be zero (latency 3..5 instead of fixed 5).
module alu_dword_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_dword_sequencer_if.slave bus,
  output logic [WIDTH-1:0]     alu_in_A,
  output logic [WIDTH-1:0]     alu_in_B,
  output logic [2:0]           alu_mode,
  output logic                 alu_carry_in,
  output logic                 alu_enable,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_carry_out,
  input  logic                 alu_zero_flag
);

  localparam logic [2:0] MODE_SHCL = 3'd3;
  localparam logic [2:0] MODE_SHCR = 3'd4;
  localparam logic [2:0] MODE_SUB  = 3'd6;
  localparam logic [2:0] MODE_ADD  = 3'd7;

`ifdef ALU_SEQ_SKIP_CARRY_EN
  localparam logic SKIP_CARRY = 1'b1;
`else
  localparam logic SKIP_CARRY = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [1:0]         pass_r, pass_s;
  logic [2:0]         mode_r, mode_s;
  logic [2*WIDTH-1:0] a_r, a_s;
  // b_r holds the effective B operand (already inverted for SUB)
  logic [2*WIDTH-1:0] b_r, b_s;
  // cin_r holds req_cin, or the carry seed for ADD/SUB
  logic               cin_r, cin_s;
  logic [WIDTH-1:0]   lo_r, lo_s;
  logic [WIDTH-1:0]   hi_r, hi_s;
  // cab_r = carry out of the low word (ca|cb); cc_r = carry of A_hi + b_hi
  logic               cab_r, cab_s;
  logic               cc_r, cc_s;

  logic [WIDTH-1:0]   alu_a_r, alu_b_r;
  logic [2:0]         alu_mode_r;
  logic               alu_cin_r, alu_en_r;

  logic               rsp_valid_r, rsp_valid_s;
  logic [2*WIDTH-1:0] rsp_result_r, rsp_result_s;
  logic               rsp_carry_r, rsp_carry_s;
  logic               rsp_zero_r, rsp_zero_s;

  // Pass-issue and completion controls produced by the next-state logic
  logic               go_s;
  logic [1:0]         drv_pass_s;
  logic [WIDTH-1:0]   drv_a_s, drv_b_s;
  logic [2:0]         drv_mode_s;
  logic               drv_cin_s;
  logic               fin_s;
  logic [2*WIDTH-1:0] fin_result_s;
  logic               fin_carry_s;

  logic               unused_zero_flag_s;

  assign unused_zero_flag_s = alu_zero_flag;

  assign bus.req_ready  = (state_r == IDLE) && !reset;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_carry  = rsp_carry_r;
  assign bus.rsp_zero   = rsp_zero_r;

  assign alu_in_A     = alu_a_r;
  assign alu_in_B     = alu_b_r;
  assign alu_mode     = alu_mode_r;
  assign alu_carry_in = alu_cin_r;
  assign alu_enable   = alu_en_r;

  // Next-state, pass sequencing and response assembly
  always_comb begin
    state_s      = state_r;
    pass_s       = pass_r;
    mode_s       = mode_r;
    a_s          = a_r;
    b_s          = b_r;
    cin_s        = cin_r;
    lo_s         = lo_r;
    hi_s         = hi_r;
    cab_s        = cab_r;
    cc_s         = cc_r;
    rsp_valid_s  = rsp_valid_r;
    rsp_result_s = rsp_result_r;
    rsp_carry_s  = rsp_carry_r;
    rsp_zero_s   = rsp_zero_r;
    go_s         = 1'b0;
    drv_pass_s   = 2'd0;
    drv_a_s      = {WIDTH{1'b0}};
    drv_b_s      = {WIDTH{1'b0}};
    drv_mode_s   = 3'd0;
    drv_cin_s    = 1'b0;
    fin_s        = 1'b0;
    fin_result_s = {2*WIDTH{1'b0}};
    fin_carry_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          state_s    = PASS;
          mode_s     = bus.req_mode;
          a_s        = bus.req_a;
          cab_s      = 1'b0;
          cc_s       = 1'b0;
          go_s       = 1'b1;
          drv_pass_s = 2'd0;
          drv_mode_s = bus.req_mode;
          drv_cin_s  = bus.req_cin;
          if (bus.req_mode == MODE_SUB) begin
            b_s        = ~bus.req_b;
            cin_s      = 1'b1;
            drv_mode_s = MODE_ADD;
            drv_cin_s  = 1'b0;
          end else if (bus.req_mode == MODE_ADD) begin
            b_s        = bus.req_b;
            cin_s      = bus.req_cin;
            drv_cin_s  = 1'b0;
          end else begin
            b_s        = bus.req_b;
            cin_s      = bus.req_cin;
          end
          // SHCR walks from the high word down; everything else starts low
          if (bus.req_mode == MODE_SHCR) begin
            drv_a_s = a_s[2*WIDTH-1:WIDTH];
            drv_b_s = b_s[2*WIDTH-1:WIDTH];
          end else begin
            drv_a_s = a_s[WIDTH-1:0];
            drv_b_s = b_s[WIDTH-1:0];
          end
        end else begin
          state_s = IDLE;
        end
      end

      PASS: begin
        case (mode_r)
          MODE_ADD, MODE_SUB: begin
            // The ALU ADD ignores carry_in, so seeds are added as B operands
            case (pass_r)
              2'd0: begin
                lo_s       = alu_out;
                cab_s      = alu_carry_out;
                go_s       = 1'b1;
                drv_mode_s = MODE_ADD;
                if (SKIP_CARRY && !cin_r) begin
                  drv_pass_s = 2'd2;
                  drv_a_s    = a_r[2*WIDTH-1:WIDTH];
                  drv_b_s    = b_r[2*WIDTH-1:WIDTH];
                end else begin
                  drv_pass_s = 2'd1;
                  drv_a_s    = alu_out;
                  drv_b_s    = {{(WIDTH-1){1'b0}}, cin_r};
                end
              end
              2'd1: begin
                lo_s       = alu_out;
                cab_s      = cab_r | alu_carry_out;
                go_s       = 1'b1;
                drv_mode_s = MODE_ADD;
                drv_pass_s = 2'd2;
                drv_a_s    = a_r[2*WIDTH-1:WIDTH];
                drv_b_s    = b_r[2*WIDTH-1:WIDTH];
              end
              2'd2: begin
                hi_s = alu_out;
                cc_s = alu_carry_out;
                if (SKIP_CARRY && !cab_r) begin
                  fin_s        = 1'b1;
                  fin_result_s = {alu_out, lo_r};
                  fin_carry_s  = alu_carry_out;
                end else begin
                  go_s       = 1'b1;
                  drv_mode_s = MODE_ADD;
                  drv_pass_s = 2'd3;
                  drv_a_s    = alu_out;
                  drv_b_s    = {{(WIDTH-1){1'b0}}, cab_r};
                end
              end
              default: begin
                hi_s         = alu_out;
                fin_s        = 1'b1;
                fin_result_s = {alu_out, lo_r};
                fin_carry_s  = cc_r | alu_carry_out;
              end
            endcase
          end

          MODE_SHCR: begin
            if (pass_r == 2'd0) begin
              hi_s       = alu_out;
              go_s       = 1'b1;
              drv_pass_s = 2'd1;
              drv_mode_s = mode_r;
              drv_a_s    = a_r[WIDTH-1:0];
              drv_b_s    = b_r[WIDTH-1:0];
              drv_cin_s  = alu_carry_out;
            end else begin
              lo_s         = alu_out;
              fin_s        = 1'b1;
              fin_result_s = {hi_r, alu_out};
              fin_carry_s  = alu_carry_out;
            end
          end

          MODE_SHCL: begin
            if (pass_r == 2'd0) begin
              lo_s       = alu_out;
              go_s       = 1'b1;
              drv_pass_s = 2'd1;
              drv_mode_s = mode_r;
              drv_a_s    = a_r[2*WIDTH-1:WIDTH];
              drv_b_s    = b_r[2*WIDTH-1:WIDTH];
              drv_cin_s  = alu_carry_out;
            end else begin
              hi_s         = alu_out;
              fin_s        = 1'b1;
              fin_result_s = {alu_out, lo_r};
              fin_carry_s  = alu_carry_out;
            end
          end

          default: begin
            // Bitwise modes: halves are independent, carry passes through
            if (pass_r == 2'd0) begin
              lo_s       = alu_out;
              go_s       = 1'b1;
              drv_pass_s = 2'd1;
              drv_mode_s = mode_r;
              drv_a_s    = a_r[2*WIDTH-1:WIDTH];
              drv_b_s    = b_r[2*WIDTH-1:WIDTH];
              drv_cin_s  = cin_r;
            end else begin
              hi_s         = alu_out;
              fin_s        = 1'b1;
              fin_result_s = {alu_out, lo_r};
              fin_carry_s  = cin_r;
            end
          end
        endcase

        if (fin_s) begin
          state_s      = RESP;
          rsp_valid_s  = 1'b1;
          rsp_result_s = fin_result_s;
          rsp_carry_s  = fin_carry_s;
          rsp_zero_s   = (fin_result_s == {2*WIDTH{1'b0}});
        end else begin
          state_s = PASS;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_s     = IDLE;
          rsp_valid_s = 1'b0;
        end else begin
          state_s = RESP;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    if (go_s) begin
      pass_s = drv_pass_s;
    end else begin
      pass_s = pass_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand, partial-result, ALU-drive and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_r       <= 2'd0;
      mode_r       <= 3'd0;
      a_r          <= {2*WIDTH{1'b0}};
      b_r          <= {2*WIDTH{1'b0}};
      cin_r        <= 1'b0;
      lo_r         <= {WIDTH{1'b0}};
      hi_r         <= {WIDTH{1'b0}};
      cab_r        <= 1'b0;
      cc_r         <= 1'b0;
      alu_a_r      <= {WIDTH{1'b0}};
      alu_b_r      <= {WIDTH{1'b0}};
      alu_mode_r   <= 3'd0;
      alu_cin_r    <= 1'b0;
      alu_en_r     <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= {2*WIDTH{1'b0}};
      rsp_carry_r  <= 1'b0;
      rsp_zero_r   <= 1'b0;
    end else begin
      pass_r       <= pass_s;
      mode_r       <= mode_s;
      a_r          <= a_s;
      b_r          <= b_s;
      cin_r        <= cin_s;
      lo_r         <= lo_s;
      hi_r         <= hi_s;
      cab_r        <= cab_s;
      cc_r         <= cc_s;
      alu_a_r      <= drv_a_s;
      alu_b_r      <= drv_b_s;
      alu_mode_r   <= drv_mode_s;
      alu_cin_r    <= drv_cin_s;
      alu_en_r     <= ~go_s;
      rsp_valid_r  <= rsp_valid_s;
      rsp_result_r <= rsp_result_s;
      rsp_carry_r  <= rsp_carry_s;
      rsp_zero_r   <= rsp_zero_s;
    end
  end

endmodule

// File: tb/tb_alu_dword_sequencer.sv
// tb_alu_dword_sequencer
// Self-checking bench: a behavioural 32-bit ALU drives alu_out, and each
// response is compared with a 64-bit arithmetic reference model.
module tb_alu_dword_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] alu_in_A, alu_in_B, alu_out;
  logic [2:0]   alu_mode;
  logic         alu_carry_in, alu_enable, alu_carry_out, alu_zero_flag;

  int tests_run = 0;
  int fails     = 0;

  logic [W-1:0] first_a;
  logic         first_cin;

  alu_dword_sequencer_if #(.WIDTH(W)) bus ();

  alu_dword_sequencer #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .alu_in_A      (alu_in_A),
    .alu_in_B      (alu_in_B),
    .alu_mode      (alu_mode),
    .alu_carry_in  (alu_carry_in),
    .alu_enable    (alu_enable),
    .alu_out       (alu_out),
    .alu_carry_out (alu_carry_out),
    .alu_zero_flag (alu_zero_flag)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: outputs are only meaningful while enabled (active low)
  always_comb begin
    alu_out       = 32'd0;
    alu_carry_out = 1'b0;
    if (!alu_enable) begin
      case (alu_mode)
        3'd0: alu_out = alu_in_A & alu_in_B;
        3'd1: alu_out = alu_in_A | alu_in_B;
        3'd2: alu_out = alu_in_A ^ alu_in_B;
        3'd3: begin
          alu_out       = {alu_in_A[W-2:0], alu_carry_in};
          alu_carry_out = alu_in_A[W-1];
        end
        3'd4: begin
          alu_out       = {alu_carry_in, alu_in_A[W-1:1]};
          alu_carry_out = alu_in_A[0];
        end
        3'd5: alu_out = ~alu_in_A;
        3'd6: {alu_carry_out, alu_out} = {1'b0, alu_in_A} - {1'b0, alu_in_B};
        default: {alu_carry_out, alu_out} = {1'b0, alu_in_A} + {1'b0, alu_in_B};
      endcase
    end
    alu_zero_flag = (alu_out == 32'd0);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 64-bit reference: result, carry and cycles from accept to rsp_valid
  function automatic void ref_op(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b,
                                 input logic c, output logic [63:0] r, output logic co, output int lat);
    logic [64:0] s;
    logic [63:0] be;
    logic        seed;
`ifdef ALU_SEQ_SKIP_CARRY_EN
    logic [32:0] lo;
`endif
    lat = 3;
    co  = c;
    r   = 64'd0;
    case (m)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd5: r = ~a;
      3'd3: begin r = {a[62:0], c}; co = a[63]; end
      3'd4: begin r = {c, a[63:1]}; co = a[0]; end
      default: begin
        be   = (m == 3'd6) ? ~b : b;
        seed = (m == 3'd6) ? 1'b1 : c;
        s    = {1'b0, a} + {1'b0, be} + {64'd0, seed};
        r    = s[63:0];
        co   = s[64];
`ifdef ALU_SEQ_SKIP_CARRY_EN
        lo  = {1'b0, a[31:0]} + {1'b0, be[31:0]} + {32'd0, seed};
        lat = 3 + (seed ? 1 : 0) + (lo[32] ? 1 : 0);
`else
        lat = 5;
`endif
      end
    endcase
  endfunction

  task automatic drive_req(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b, input logic c);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mode  = m;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = c;
  endtask

  // Expects the request already driven; waits for acceptance, checks the response
  task automatic collect(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b,
                         input logic c, input int hold, input bit hs);
    logic [63:0] er;
    logic        ec;
    int          el;
    int          guard;
    int          lat;
    int          en_cnt;
    ref_op(m, a, b, c, er, ec, el);
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_val("accept", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    first_a   = alu_in_A;
    first_cin = alu_carry_in;
    lat    = 1;
    en_cnt = 0;
    while (!bus.rsp_valid && lat < 20) begin
      if (!alu_enable) en_cnt++;
      @(negedge clk);
      lat++;
    end
    check_val("latency", 64'(lat), 64'(el));
    check_val("passes", 64'(en_cnt), 64'(el - 1));
    check_val("result", bus.rsp_result, er);
    check_val("carry", 64'(bus.rsp_carry), 64'(ec));
    check_val("zero", 64'(bus.rsp_zero), 64'(er == 64'd0));
    check_val("busy_ready", 64'(bus.req_ready), 64'd0);
    check_val("resp_enable", 64'(alu_enable), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_result", bus.rsp_result, er);
      check_val("hold_valid", 64'(bus.rsp_valid), 64'd1);
    end
    if (hs) begin
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check_val("rsp_drop", 64'(bus.rsp_valid), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [2:0]  rm;
    bit          seen_valid;
    bus.req_valid = 1'b0;
    bus.req_mode  = 3'd0;
    bus.req_a     = 64'd0;
    bus.req_b     = 64'd0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("rst_rsp_result", bus.rsp_result, 64'd0);
    check_val("rst_rsp_flags", {62'd0, bus.rsp_carry, bus.rsp_zero}, 64'd0);
    check_val("rst_alu_enable", 64'(alu_enable), 64'd1);
    check_val("rst_alu_ops", {alu_in_A, alu_in_B}, 64'd0);
    check_val("rst_alu_ctl", {60'd0, alu_mode, alu_carry_in}, 64'd0);
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("rel_req_ready", 64'(bus.req_ready), 64'd1);

    // Directed cases
    drive_req(3'd7, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
    collect(3'd7, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b1);
    drive_req(3'd6, 64'd0, 64'd1, 1'b0);
    collect(3'd6, 64'd0, 64'd1, 1'b0, 0, 1'b1);
    drive_req(3'd6, 64'd5, 64'd5, 1'b0);
    collect(3'd6, 64'd5, 64'd5, 1'b0, 1, 1'b1);
    drive_req(3'd3, 64'h8000_0000_8000_0000, 64'd0, 1'b1);
    collect(3'd3, 64'h8000_0000_8000_0000, 64'd0, 1'b1, 0, 1'b1);
    check_val("shcl_first_a", 64'(first_a), 64'h8000_0000);
    drive_req(3'd4, 64'h0000_0001_0000_0001, 64'd0, 1'b0);
    collect(3'd4, 64'h0000_0001_0000_0001, 64'd0, 1'b0, 0, 1'b1);
    check_val("shcr_first_a", 64'(first_a), 64'h1);
    check_val("shcr_first_cin", 64'(first_cin), 64'd0);

    // Backpressure with a queued AND request
    drive_req(3'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    collect(3'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_mode  = 3'd0;
    bus.req_a     = 64'h1234_5678_9ABC_DEF0;
    bus.req_b     = 64'h0F0F_FFFF_0000_FF00;
    bus.req_cin   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val("bp_result", bus.rsp_result, 64'h0F0F_0F0F_0F0F_0F0F);
      check_val("bp_ready", 64'(bus.req_ready), 64'd0);
      check_val("bp_valid", 64'(bus.rsp_valid), 64'd1);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    check_val("hs_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_val("post_hs_ready", 64'(bus.req_ready), 64'd1);
    check_val("post_hs_valid", 64'(bus.rsp_valid), 64'd0);
    collect(3'd0, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_FFFF_0000_FF00, 1'b1, 1, 1'b1);

    // Reset during p2 of an ADD
    drive_req(3'd7, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("p2_enable", 64'(alu_enable), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_enable", 64'(alu_enable), 64'd1);
    check_val("abort_valid", 64'(bus.rsp_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("abort_ready", 64'(bus.req_ready), 64'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    check_val("abort_no_rsp", 64'(seen_valid), 64'd0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      rm = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        1: ra = 64'($urandom_range(0, 3));
        default: ra = {$urandom(), $urandom()};
      endcase
      case ($urandom_range(0, 3))
        0: rb = 64'hFFFF_FFFF_FFFF_FFFF;
        1: rb = 64'($urandom_range(0, 3));
        default: rb = {$urandom(), $urandom()};
      endcase
      drive_req(rm, ra, rb, 1'($urandom_range(0, 1)));
      collect(rm, ra, rb, bus.req_cin, int'($urandom_range(0, 2)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
